window_frame_ctrl: RTL and testbench

WINDOW_FRAME_CTRL -- requirements
Module: window_frame_ctrl

---
 rtl/win_ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 27 ++
 rtl/window_frame_ctrl.sv | 159 +++++++++++++++
 tb/tb_window_frame_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/win_ctrl_pkg.sv
// Shared types for the window frame controller: FSM state encoding and
// the width of the frame statistics counters.
package win_ctrl_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

endpackage : win_ctrl_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk_in : clock (posedge)
//   clear  : synchronous clear to zero, wins over inc
//   inc    : add one, unless already at all-ones
//   value  : current count (registered)
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;

    always_ff @(posedge clk_in) begin
        if (clear) begin
            value_q <= '0;
        end else if (inc && (value_q != '1)) begin
            value_q <= value_q + WIDTH'(1);
        end
    end

    assign value = value_q;

endmodule : sat_counter

// File: rtl/window_frame_ctrl.sv
// Frames an audio sample stream into FRAME_LEN-sample analysis frames for a
// windowing/FFT datapath. A frame only starts when the FFT can absorb it, is
// never emitted partially, and is abandoned (frame_abort) if the FFT loses
// readiness mid-frame.
//   clk_in, rst_in                    : clock, synchronous active-high reset
//   enable                            : frames may start; drop finishes current frame
//   audio_sample(_valid), fft_ready   : input stream and downstream readiness
//   win_sample(_valid), win_coeff_addr: forwarded sample and its window index
//   frame_first, frame_last           : index 0 / index FRAME_LEN-1 markers
//   frame_abort                       : one-cycle pulse on an abandoned frame
//   busy                              : high while in RUN
//   frames_done, frames_dropped       : saturating frame statistics
module window_frame_ctrl
    import win_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FRAME_LEN  = 4096,
    parameter int unsigned ADDR_W     = $clog2(FRAME_LEN)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] audio_sample,
    input  logic                         audio_sample_valid,
    input  logic                         fft_ready,
    output logic signed [DATA_WIDTH-1:0] win_sample,
    output logic                         win_sample_valid,
    output logic        [ADDR_W-1:0]     win_coeff_addr,
    output logic                         frame_first,
    output logic                         frame_last,
    output logic                         frame_abort,
    output logic                         busy,
    output logic        [CNT_W-1:0]      frames_done,
    output logic        [CNT_W-1:0]      frames_dropped
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    state_e                         state_q, state_d;
    logic        [ADDR_W-1:0]       idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0]   sample_q, sample_d;
    logic                           valid_q, valid_d;
    logic        [ADDR_W-1:0]       addr_q, addr_d;
    logic                           first_q, first_d;
    logic                           last_q, last_d;
    logic                           abort_q, abort_d;
    logic                           busy_q;
    logic                           done_inc_c;
    logic                           drop_inc_c;

    // State register and registered outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            abort_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            first_q  <= first_d;
            last_q   <= last_d;
            abort_q  <= abort_d;
            busy_q   <= (state_d == ST_RUN);
        end
    end

    // Next-state, frame index and forwarding decisions
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        valid_d    = 1'b0;
        addr_d     = '0;
        first_d    = 1'b0;
        last_d     = 1'b0;
        abort_d    = 1'b0;
        done_inc_c = 1'b0;
        drop_inc_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_ARM;
            end
            ST_ARM: begin
                // A frame only starts on a sample the FFT can take; others are dropped silently.
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (audio_sample_valid && fft_ready) begin
                    valid_d = 1'b1;
                    first_d = 1'b1;
                    idx_d   = ADDR_W'(1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (audio_sample_valid) begin
                    if (idx_q == LAST_IDX) begin
                        // Closing sample is always forwarded; readiness decides the next frame.
                        valid_d    = 1'b1;
                        addr_d     = idx_q;
                        last_d     = 1'b1;
                        done_inc_c = 1'b1;
                        idx_d      = '0;
                        if (enable && fft_ready) state_d = ST_RUN;
                        else if (enable)         state_d = ST_ARM;
                        else                     state_d = ST_IDLE;
                    end else if (fft_ready) begin
                        valid_d = 1'b1;
                        addr_d  = idx_q;
                        first_d = (idx_q == '0);
                        idx_d   = idx_q + ADDR_W'(1);
                    end else begin
                        abort_d    = 1'b1;
                        drop_inc_c = 1'b1;
                        idx_d      = '0;
                        state_d    = ST_ARM;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        sample_d = valid_d ? audio_sample : '0;
    end

    sat_counter #(.WIDTH(CNT_W)) u_done_cnt (
        .clk_in (clk_in),
        .clear  (rst_in),
        .inc    (done_inc_c),
        .value  (frames_done)
    );

    sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
        .clk_in (clk_in),
        .clear  (rst_in),
        .inc    (drop_inc_c),
        .value  (frames_dropped)
    );

    assign win_sample       = sample_q;
    assign win_sample_valid = valid_q;
    assign win_coeff_addr   = addr_q;
    assign frame_first      = first_q;
    assign frame_last       = last_q;
    assign frame_abort      = abort_q;
    assign busy             = busy_q;

endmodule : window_frame_ctrl

// File: tb/tb_window_frame_ctrl.sv
// Scoreboard bench for window_frame_ctrl with FRAME_LEN=16.
module tb_window_frame_ctrl;

    localparam int FL = 16;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  audio_sample = '0;
    logic        audio_sample_valid = 1'b0;
    logic        fft_ready = 1'b0;
    logic [7:0]  win_sample;
    logic        win_sample_valid;
    logic [3:0]  win_coeff_addr;
    logic        frame_first, frame_last, frame_abort, busy;
    logic [15:0] frames_done, frames_dropped;

    logic        sat_clr = 1'b1;
    logic        sat_inc = 1'b0;
    logic [3:0]  sat_val;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] s;
        int         addr;
        bit         first;
        bit         last;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int   abort_q[$];

    window_frame_ctrl #(.DATA_WIDTH(8), .FRAME_LEN(FL)) dut (
        .clk_in             (clk),
        .rst_in             (rst_in),
        .enable             (enable),
        .audio_sample       (audio_sample),
        .audio_sample_valid (audio_sample_valid),
        .fft_ready          (fft_ready),
        .win_sample         (win_sample),
        .win_sample_valid   (win_sample_valid),
        .win_coeff_addr     (win_coeff_addr),
        .frame_first        (frame_first),
        .frame_last         (frame_last),
        .frame_abort        (frame_abort),
        .busy               (busy),
        .frames_done        (frames_done),
        .frames_dropped     (frames_dropped)
    );

    sat_counter #(.WIDTH(4)) u_sat (
        .clk_in (clk),
        .clear  (sat_clr),
        .inc    (sat_inc),
        .value  (sat_val)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, pending fwd=%0d abort=%0d", exp_q.size(), abort_q.size());
        $fatal(1, "watchdog");
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a sample or an abort.
    always @(negedge clk) begin
        if (win_sample_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_fwd: got addr %0d sample %0d, expected none (cycle %0d)",
                         win_coeff_addr, win_sample, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("fwd_sample", 32'(win_sample), 32'(e.s));
                chk("fwd_addr", 32'(win_coeff_addr), 32'(e.addr));
                chk("fwd_first", 32'(frame_first), 32'(e.first));
                chk("fwd_last", 32'(frame_last), 32'(e.last));
                chk("fwd_latency_cycle", 32'(cyc), 32'(e.at));
            end
        end else if (frame_first || frame_last) begin
            n_cmp++; n_bad++;
            $display("FAIL stray_marker: got first=%0d last=%0d, expected 0 without valid", frame_first, frame_last);
        end
        if (frame_abort) begin
            if (abort_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_abort: got pulse, expected none (cycle %0d)", cyc);
            end else begin
                chk("abort_cycle", 32'(cyc), 32'(abort_q.pop_front()));
            end
        end
    end

    // One strobe, then three idle cycles; pushes what the DUT must answer.
    task automatic strobe(input logic [7:0] s, input logic rdy, input bit fwd, input int addr, input bit abrt);
        @(posedge clk); #1;
        audio_sample       = s;
        audio_sample_valid = 1'b1;
        fft_ready          = rdy;
        if (fwd) exp_q.push_back('{s: s, addr: addr, first: (addr == 0), last: (addr == FL - 1), at: cyc + 1});
        if (abrt) abort_q.push_back(cyc + 1);
        @(posedge clk); #1;
        audio_sample_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst_in = 1'b1;
        @(posedge clk); #1; rst_in = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(win_sample_valid), 0);
        chk("rst_sample", 32'(win_sample), 0);
        chk("rst_addr", 32'(win_coeff_addr), 0);
        chk("rst_abort", 32'(frame_abort), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frames_done), 0);
        chk("rst_dropped", 32'(frames_dropped), 0);
        #1 rst_in = 1'b0;

        // Two back-to-back frames
        enable = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 2 * FL; i++) strobe(8'(i * 7 + 3), 1'b1, 1'b1, i % FL, 1'b0);
        @(negedge clk);
        chk("t1_done", 32'(frames_done), 2);
        chk("t1_dropped", 32'(frames_dropped), 0);
        chk("t1_busy", 32'(busy), 1);

        // ARM discards until ready, then abort on the 9th strobe of the frame
        pulse_reset();
        @(negedge clk);
        chk("t2_done_cleared", 32'(frames_done), 0);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 5; i++) strobe(8'(100 + i), 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        chk("t2_busy_arm", 32'(busy), 0);
        for (int i = 0; i < 8; i++) strobe(8'(50 + i), 1'b1, 1'b1, i, 1'b0);
        chk("t2_dropped", 32'(frames_dropped), 0);
        strobe(8'hAA, 1'b0, 1'b0, 0, 1'b1);
        @(negedge clk);
        chk("t3_dropped", 32'(frames_dropped), 1);
        chk("t3_busy", 32'(busy), 0);
        strobe(8'hBB, 1'b0, 1'b0, 0, 1'b0);

        // Restart, then enable drops at addr 3: frame still completes
        for (int i = 0; i < 4; i++) strobe(8'(200 + i), 1'b1, 1'b1, i, 1'b0);
        #1 enable = 1'b0;
        for (int i = 4; i < FL; i++) strobe(8'(8'hF0 - i), (i != FL - 1), 1'b1, i, 1'b0);
        @(negedge clk);
        chk("t4_done", 32'(frames_done), 1);
        chk("t4_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) strobe(8'(i), 1'b1, 1'b0, 0, 1'b0);
        chk("t4_dropped", 32'(frames_dropped), 1);

        // Reset mid-frame at addr 9
        #1 enable = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 10; i++) strobe(8'(i + 20), 1'b1, 1'b1, i, 1'b0);
        pulse_reset();
        @(negedge clk);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_valid", 32'(win_sample_valid), 0);
        chk("t5_done", 32'(frames_done), 0);
        chk("t5_dropped", 32'(frames_dropped), 0);
        repeat (2) @(posedge clk);
        for (int i = 0; i < FL; i++) strobe(8'(i + 60), 1'b1, 1'b1, i, 1'b0);
        @(negedge clk);
        chk("t5_done_after", 32'(frames_done), 1);

        // Saturation on a narrow counter instance
        @(posedge clk); #1 sat_clr = 1'b0; sat_inc = 1'b1;
        repeat (14) @(posedge clk);
        #1 chk("sat_14", 32'(sat_val), 14);
        repeat (6) @(posedge clk);
        #1 chk("sat_hold", 32'(sat_val), 15);
        sat_inc = 1'b0; sat_clr = 1'b1;
        @(posedge clk);
        #1 chk("sat_clear", 32'(sat_val), 0);

        repeat (4) @(posedge clk);
        chk("pending_fwd", 32'(exp_q.size()), 0);
        chk("pending_abort", 32'(abort_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_window_frame_ctrl
